// File: rtl/processor_pkg.sv
// Shared definitions for the 16-bit pipelined processor: opcodes, NOP,
// fetch state encoding and two-word instruction detection.
package processor_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPCODE_W = 5;

  // Opcodes whose instruction carries a second (immediate) word
  localparam logic [OPCODE_W-1:0] OP_IADD = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_LDM  = 5'b10100;
  localparam logic [OPCODE_W-1:0] OP_LDD  = 5'b10101;
  localparam logic [OPCODE_W-1:0] OP_STD  = 5'b10110;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  typedef enum logic {
    FETCH     = 1'b0,
    FETCH_IMM = 1'b1
  } fetch_state_t;

  function automatic logic is_two_word(input logic [OPCODE_W-1:0] opcode);
    return (opcode == OP_IADD) || (opcode == OP_LDM) ||
           (opcode == OP_LDD)  || (opcode == OP_STD);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, assembles one- and two-word
// instructions and drives the IF/ID pipeline register (stall/jump aware).
module fetch_stage
  import processor_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_taken,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       instruction_buf,
  output logic [15:0]       immediate_buf,
  output logic [ADDR_W-1:0] pc_buf,
  output logic              valid_buf
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_first_word;
  logic [15:0]       r_instruction;
  logic [15:0]       r_immediate;
  logic [ADDR_W-1:0] r_pc_buf;
  logic              r_valid;

  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_two_word;

  // Address of the word after the current PC; wraps modulo 2^ADDR_W
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_two_word = is_two_word(imem_data[15:11]);

  // PC, fetch state and IF/ID register; priority reset > jump > stall > fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_state       <= FETCH;
      r_first_word  <= NOP;
      r_instruction <= NOP;
      r_immediate   <= '0;
      r_pc_buf      <= '0;
      r_valid       <= 1'b0;
    end else if (jump_taken) begin
      r_pc          <= jump_target;
      r_state       <= FETCH;
      r_instruction <= NOP;
      r_immediate   <= '0;
      r_pc_buf      <= '0;
      r_valid       <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        FETCH: begin
          r_pc <= w_pc_inc;
          if (w_two_word) begin
            // Hold the first word and emit a bubble while the immediate is fetched
            r_first_word  <= imem_data;
            r_state       <= FETCH_IMM;
            r_instruction <= NOP;
            r_immediate   <= '0;
            r_pc_buf      <= '0;
            r_valid       <= 1'b0;
          end else begin
            r_instruction <= imem_data;
            r_immediate   <= '0;
            r_pc_buf      <= w_pc_inc;
            r_valid       <= 1'b1;
          end
        end
        FETCH_IMM: begin
          r_pc          <= w_pc_inc;
          r_state       <= FETCH;
          r_instruction <= r_first_word;
          r_immediate   <= imem_data;
          r_pc_buf      <= w_pc_inc;
          r_valid       <= 1'b1;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign imem_addr       = r_pc;
  assign instruction_buf = r_instruction;
  assign immediate_buf   = r_immediate;
  assign pc_buf          = r_pc_buf;
  assign valid_buf       = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan cases plus
// randomized programs/stalls/jumps/resets against an instruction-level model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump_taken;
  logic [15:0] jump_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instruction_buf;
  logic [15:0] immediate_buf;
  logic [15:0] pc_buf;
  logic        valid_buf;

  logic [15:0] mem [65536];

  int n_checks;
  int n_errors;

  // Reference model state: where fetch is, and a pending first word if any
  logic [15:0] m_pc;
  logic [15:0] m_first;
  bit          m_pending;
  logic [15:0] m_ins;
  logic [15:0] m_imm;
  logic [15:0] m_pcb;
  bit          m_valid;

  fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .jump_taken      (jump_taken),
    .jump_target     (jump_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .instruction_buf (instruction_buf),
    .immediate_buf   (immediate_buf),
    .pc_buf          (pc_buf),
    .valid_buf       (valid_buf)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit two_word_op(input logic [15:0] w);
    logic [4:0] op;
    op = w[15:11];
    return op == 5'b01011 || op == 5'b10100 || op == 5'b10101 || op == 5'b10110;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_first = 16'h0; m_pending = 0;
    m_ins = 16'h0; m_imm = 16'h0; m_pcb = 16'h0; m_valid = 0;
  endtask

  // One clock edge of the architectural fetch rules
  task automatic model_step(input bit st, input bit jt, input logic [15:0] tgt);
    logic [15:0] word;
    word = mem[m_pc];
    if (jt) begin
      m_pc = tgt; m_pending = 0;
      m_ins = 16'h0; m_imm = 16'h0; m_pcb = 16'h0; m_valid = 0;
    end else if (!st) begin
      if (m_pending) begin
        m_ins = m_first; m_imm = word; m_pcb = m_pc + 16'd1; m_valid = 1;
        m_pending = 0;
      end else if (two_word_op(word)) begin
        m_first = word; m_pending = 1;
        m_ins = 16'h0; m_imm = 16'h0; m_pcb = 16'h0; m_valid = 0;
      end else begin
        m_ins = word; m_imm = 16'h0; m_pcb = m_pc + 16'd1; m_valid = 1;
      end
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_pc));
    check({tag, ".instr"},     32'(instruction_buf), 32'(m_ins));
    check({tag, ".imm"},       32'(immediate_buf), 32'(m_imm));
    check({tag, ".pc_buf"},    32'(pc_buf), 32'(m_pcb));
    check({tag, ".valid"},     32'(valid_buf), 32'(m_valid));
  endtask

  // Called just after a negedge; drives inputs, steps the model, checks at next negedge
  task automatic cycle(input bit st, input bit jt, input logic [15:0] tgt, input string tag);
    stall = st; jump_taken = jt; jump_target = tgt;
    model_step(st, jt, tgt);
    @(negedge clk);
    compare_model(tag);
  endtask

  // Mid-cycle reset; outputs must clear before any clock edge
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst.imem_addr", 32'(imem_addr), 32'h0);
    check("rst.instr",     32'(instruction_buf), 32'h0);
    check("rst.imm",       32'(immediate_buf), 32'h0);
    check("rst.pc_buf",    32'(pc_buf), 32'h0);
    check("rst.valid",     32'(valid_buf), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [4:0] ops [4];
    ops[0] = 5'b01011; ops[1] = 5'b10100; ops[2] = 5'b10101; ops[3] = 5'b10110;
    if ($urandom_range(0, 99) < 30)
      return {ops[$urandom_range(0, 3)], 11'($urandom)};
    return 16'($urandom);
  endfunction

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; stall = 1'b0; jump_taken = 1'b0; jump_target = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    compare_model("por");
    reset = 1'b0;

    // One-word sequence
    mem[0] = 16'h0800; mem[1] = 16'h1100;
    cycle(0, 0, 16'h0, "ow1");
    check("ow1.instr", 32'(instruction_buf), 32'h0800);
    check("ow1.pc_buf", 32'(pc_buf), 32'h1);
    check("ow1.valid", 32'(valid_buf), 32'h1);
    cycle(0, 0, 16'h0, "ow2");
    check("ow2.instr", 32'(instruction_buf), 32'h1100);
    check("ow2.pc_buf", 32'(pc_buf), 32'h2);
    check("ow2.valid", 32'(valid_buf), 32'h1);

    // Two-word LDM, asynchronous reset mid-run
    do_reset();
    mem[0] = 16'hA100; mem[1] = 16'h1234; mem[2] = 16'h0000;
    cycle(0, 0, 16'h0, "tw1");
    check("tw1.valid", 32'(valid_buf), 32'h0);
    cycle(0, 0, 16'h0, "tw2");
    check("tw2.instr", 32'(instruction_buf), 32'hA100);
    check("tw2.imm", 32'(immediate_buf), 32'h1234);
    check("tw2.pc_buf", 32'(pc_buf), 32'h2);
    check("tw2.valid", 32'(valid_buf), 32'h1);

    // Stall three cycles while in FETCH_IMM
    do_reset();
    cycle(0, 0, 16'h0, "st0");
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 16'h0, "stall");
      check("stall.imem_addr", 32'(imem_addr), 32'h1);
      check("stall.valid", 32'(valid_buf), 32'h0);
    end
    cycle(0, 0, 16'h0, "st_rel");
    check("st_rel.instr", 32'(instruction_buf), 32'hA100);
    check("st_rel.imm", 32'(immediate_buf), 32'h1234);
    check("st_rel.pc_buf", 32'(pc_buf), 32'h2);

    // Jump while in FETCH_IMM discards the first word
    do_reset();
    mem[16'h0040] = 16'h0800;
    cycle(0, 0, 16'h0, "jp0");
    cycle(0, 1, 16'h0040, "jp1");
    check("jp1.valid", 32'(valid_buf), 32'h0);
    check("jp1.imem_addr", 32'(imem_addr), 32'h40);
    cycle(0, 0, 16'h0, "jp2");
    check("jp2.instr", 32'(instruction_buf), 32'h0800);
    check("jp2.imm", 32'(immediate_buf), 32'h0);

    // Jump and stall together: jump wins
    cycle(1, 1, 16'h0123, "jst");
    check("jst.imem_addr", 32'(imem_addr), 32'h123);

    // Two-word instruction straddling the address wrap
    mem[16'hFFFF] = 16'hA100; mem[0] = 16'h5555;
    cycle(0, 1, 16'hFFFF, "wr0");
    cycle(0, 0, 16'h0, "wr1");
    check("wr1.valid", 32'(valid_buf), 32'h0);
    check("wr1.imem_addr", 32'(imem_addr), 32'h0);
    cycle(0, 0, 16'h0, "wr2");
    check("wr2.instr", 32'(instruction_buf), 32'hA100);
    check("wr2.imm", 32'(immediate_buf), 32'h5555);
    check("wr2.pc_buf", 32'(pc_buf), 32'h1);
    check("wr2.imem_addr", 32'(imem_addr), 32'h1);

    // Randomized programs, stalls, jumps and resets
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    for (int i = 16'hFFF0; i < 65536; i++) mem[i] = rand_word();
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [15:0] tgt;
      r = $urandom_range(0, 999);
      tgt = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                        : 16'($urandom_range(0, 255));
      if (r < 8) do_reset();
      else cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 6, tgt, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
